conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Sequencer for the 2D-convolution MAC datapath. For each output pixel it walks the KxK window over the input image, issues image/kernel memory reads, and drives the accumulator clear/enable strobes. It then pulses `load_new_value` into the result register and presents the pixel downstream with a valid/ready handshake. It sits between the top-level start/done control and the memories, accumulator and result register.

## Interface
- `IMG_W`, default 8: input image width in pixels (>= K).
- `IMG_H`, default 8: input image height in pixels (>= K).
- `K`, default 3: kernel edge size (KxK taps, >= 1).
- `IMG_AW`, default $clog2(IMG_W*IMG_H): image address width.
- `KER_AW`, default $clog2(K*K) (min 1): kernel address width.
- `OUT_AW`, default $clog2((IMG_W-K+1)*(IMG_H-K+1)) (min 1): output pixel index width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a full-frame convolution; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until DONE completes.
- `done`  out  1  one-cycle pulse after the last output pixel handshakes.
- `rd_en`  out  1  image/kernel memory read strobe.
- `img_addr`  out  IMG_AW  image address, (row+ky)*IMG_W + (col+kx).
- `ker_addr`  out  KER_AW  kernel address, ky*K + kx.
- `acc_clear`  out  1  zero the accumulator.
- `acc_en`  out  1  accumulate current memory data (rd_en delayed 1 cycle).
- `load_new_value`  out  1  capture accumulator into the result register.
- `out_valid`  out  1  result register holds a pixel for `out_idx`.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_idx`  out  OUT_AW  output pixel index, row*(IMG_W-K+1) + col.

## Operation
- All outputs registered. Reset value of every output is 0; state is IDLE; row/col/ky/kx are 0.
- Memories have fixed 1-cycle read latency: data for an rd_en in cycle t is valid in t+1, which is when acc_en is high.
- States:
  - IDLE: wait for start. On start: row=col=0, go to CLEAR.
  - CLEAR: acc_clear=1 for one cycle; ky=kx=0; go to MAC.
  - MAC: rd_en=1 for exactly K*K cycles. kx increments; on kx==K-1 it wraps to 0 and ky increments. After tap (K-1,K-1), go to DRAIN.
  - DRAIN: one cycle (the last acc_en fires here); go to LOAD.
  - LOAD: load_new_value=1 for one cycle; go to OUT_WAIT.
  - OUT_WAIT: out_valid=1, out_idx held stable until out_valid && out_ready. On handshake:
    - if last pixel (row==IMG_H-K and col==IMG_W-K), go to DONE;
    - else col increments (wraps to 0 at IMG_W-K+1 with row+1), go to CLEAR.
  - DONE: done=1 for one cycle, busy=0 afterwards; go to IDLE.
- Raster order: col fastest, then row. Output count is (IMG_W-K+1)*(IMG_H-K+1).
- start is ignored in any state other than IDLE.
- out_ready is ignored outside OUT_WAIT.
- rd_en, acc_clear, acc_en and load_new_value are mutually exclusive in any cycle, except that acc_en overlaps rd_en inside MAC.
- Address arithmetic must not overflow: max img_addr = IMG_W*IMG_H-1; max ker_addr = K*K-1.
- K==1: MAC lasts 1 cycle; everything else unchanged.

## Timing
- start sampled high in IDLE at cycle s: CLEAR at s+1, first rd_en at s+2, busy=1 from s+1.
- Per pixel, with out_ready held high: CLEAR 1 + MAC K*K + DRAIN 1 + LOAD 1 + OUT_WAIT 1 = K*K+4 cycles.
- out_valid asserts the cycle after load_new_value, when the result register holds the new value.
- Each backpressure cycle (out_ready low) extends OUT_WAIT by one cycle. No reads are issued and the accumulator is untouched during the stall.
- done pulses the cycle after the final handshake; busy falls the cycle after done.
- rst high in any cycle: next cycle all outputs are 0 and state is IDLE. An in-flight frame is abandoned and never resumed.

## Test plan
- Reset: hold rst 2 cycles mid-MAC -> next cycle rd_en, acc_en, out_valid, busy and done are 0; a new start afterwards begins at img_addr 0.
- Single pixel, defaults, out_ready=1:
  - img_addr sequence is 0,1,2,8,9,10,16,17,18 and ker_addr sequence is 0..8;
  - acc_en lags rd_en by exactly 1 cycle;
  - load_new_value at s+12, out_valid with out_idx=0 at s+13.
- Full frame 8x8, K=3, out_ready=1 -> 36 handshakes with out_idx 0..35 in order; done at s+1+36*13; pixel 6 window starts at img_addr 8.
- Backpressure: out_ready low for 5 cycles on pixel 3 -> out_valid and out_idx=3 held stable, no rd_en during the stall, frame finishes exactly 5 cycles later.
- Start while busy: pulse start during MAC and OUT_WAIT -> no restart, addresses unaffected, exactly one done.
- K=1, IMG_W=IMG_H=4 -> 16 pixels at 5 cycles each; img_addr equals out_idx each time; ker_addr always 0.

Source files
------------

// File: rtl/conv_window_if.sv
// Handshake and memory/accumulator strobe bundle between conv_window_ctrl and its
// surroundings. The controller takes the master side.
`timescale 1ns/1ps
interface conv_window_if #(
  parameter int IMG_AW = 6,
  parameter int KER_AW = 4,
  parameter int OUT_AW = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [IMG_AW-1:0] img_addr;
  logic [KER_AW-1:0] ker_addr;
  logic              acc_clear;
  logic              acc_en;
  logic              load_new_value;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_AW-1:0] out_idx;

  modport master (
    input  start,
    input  out_ready,
    output busy,
    output done,
    output rd_en,
    output img_addr,
    output ker_addr,
    output acc_clear,
    output acc_en,
    output load_new_value,
    output out_valid,
    output out_idx
  );

  modport slave (
    output start,
    output out_ready,
    input  busy,
    input  done,
    input  rd_en,
    input  img_addr,
    input  ker_addr,
    input  acc_clear,
    input  acc_en,
    input  load_new_value,
    input  out_valid,
    input  out_idx
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Window sequencer for the 2D-convolution MAC datapath: walks the KxK window per
// output pixel in raster order and hands each finished pixel downstream.
`timescale 1ns/1ps
module conv_window_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int IMG_AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  parameter int KER_AW = (K * K > 1) ? $clog2(K * K) : 1,
  parameter int OUT_AW = ((IMG_W - K + 1) * (IMG_H - K + 1) > 1) ?
                         $clog2((IMG_W - K + 1) * (IMG_H - K + 1)) : 1
) (
  input  logic          clk,
  input  logic          rst,
  conv_window_if.master bus
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_MAC      = 3'd2,
    S_DRAIN    = 3'd3,
    S_LOAD     = 3'd4,
    S_OUT_WAIT = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [KW-1:0]     ky_q, ky_d;
  logic [KW-1:0]     kx_q, kx_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              acc_clear_q, acc_clear_d;
  logic              acc_en_q, acc_en_d;
  logic              load_q, load_d;
  logic              out_valid_q, out_valid_d;
  logic [IMG_AW-1:0] img_addr_q, img_addr_d;
  logic [KER_AW-1:0] ker_addr_q, ker_addr_d;
  logic [OUT_AW-1:0] out_idx_q, out_idx_d;

  // Every intermediate stays below IMG_W*IMG_H, so IMG_AW-wide arithmetic cannot wrap.
  function automatic logic [IMG_AW-1:0] img_addr_f(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c,
    input logic [KW-1:0]    y,
    input logic [KW-1:0]    x
  );
    img_addr_f = (IMG_AW'(r) + IMG_AW'(y)) * IMG_AW'(IMG_W) + IMG_AW'(c) + IMG_AW'(x);
  endfunction

  function automatic logic [KER_AW-1:0] ker_addr_f(
    input logic [KW-1:0] y,
    input logic [KW-1:0] x
  );
    ker_addr_f = KER_AW'(y) * KER_AW'(K) + KER_AW'(x);
  endfunction

  function automatic logic [OUT_AW-1:0] out_idx_f(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c
  );
    out_idx_f = OUT_AW'(r) * OUT_AW'(OUT_W) + OUT_AW'(c);
  endfunction

  // Next-state and window/pixel counter update.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        ky_d    = '0;
        kx_d    = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(K - 1)) begin
            ky_d    = '0;
            state_d = S_DRAIN;
          end else begin
            ky_d    = ky_q + KW'(1'b1);
            state_d = S_MAC;
          end
        end else begin
          kx_d    = kx_q + KW'(1'b1);
          state_d = S_MAC;
        end
      end
      S_DRAIN: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (bus.out_ready) begin
          if ((row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
            if (col_q == COL_W'(OUT_W - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1'b1);
            end else begin
              col_d = col_q + COL_W'(1'b1);
              row_d = row_q;
            end
          end
        end else begin
          state_d = S_OUT_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_MAC);
    acc_clear_d = (state_d == S_CLEAR);
    acc_en_d    = rd_en_q;
    load_d      = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT_WAIT);
    img_addr_d  = '0;
    ker_addr_d  = '0;
    out_idx_d   = out_idx_q;
    if (rd_en_d) begin
      img_addr_d = img_addr_f(row_d, col_d, ky_d, kx_d);
      ker_addr_d = ker_addr_f(ky_d, kx_d);
    end else begin
      img_addr_d = '0;
      ker_addr_d = '0;
    end
    if (out_valid_d) begin
      out_idx_d = out_idx_f(row_d, col_d);
    end else begin
      out_idx_d = out_idx_q;
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      acc_clear_q <= 1'b0;
      acc_en_q    <= 1'b0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      img_addr_q  <= '0;
      ker_addr_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      acc_clear_q <= acc_clear_d;
      acc_en_q    <= acc_en_d;
      load_q      <= load_d;
      out_valid_q <= out_valid_d;
      img_addr_q  <= img_addr_d;
      ker_addr_q  <= ker_addr_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.rd_en          = rd_en_q;
  assign bus.img_addr       = img_addr_q;
  assign bus.ker_addr       = ker_addr_q;
  assign bus.acc_clear      = acc_clear_q;
  assign bus.acc_en         = acc_en_q;
  assign bus.load_new_value = load_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_idx        = out_idx_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: an 8x8/K=3 instance and a 4x4/K=1 instance
// checked cycle by cycle against the expected per-pixel timeline.
`timescale 1ns/1ps
module tb_conv_window_ctrl;

  logic clk;
  logic rst;
  logic sel_b;
  int   errors;
  int   checks;
  int   p0_tab [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  logic [31:0] o_busy, o_done, o_rd, o_acc, o_clr, o_load, o_valid, o_img, o_ker, o_idx;

  conv_window_if #(.IMG_AW(6), .KER_AW(4), .OUT_AW(6)) a_if ();
  conv_window_if #(.IMG_AW(4), .KER_AW(1), .OUT_AW(4)) b_if ();

  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .K(3)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux so one checking routine serves both instances.
  always_comb begin
    if (sel_b) begin
      o_busy = 32'(b_if.busy);      o_done  = 32'(b_if.done);
      o_rd   = 32'(b_if.rd_en);     o_acc   = 32'(b_if.acc_en);
      o_clr  = 32'(b_if.acc_clear); o_load  = 32'(b_if.load_new_value);
      o_valid = 32'(b_if.out_valid);
      o_img  = 32'(b_if.img_addr);  o_ker   = 32'(b_if.ker_addr);
      o_idx  = 32'(b_if.out_idx);
    end else begin
      o_busy = 32'(a_if.busy);      o_done  = 32'(a_if.done);
      o_rd   = 32'(a_if.rd_en);     o_acc   = 32'(a_if.acc_en);
      o_clr  = 32'(a_if.acc_clear); o_load  = 32'(a_if.load_new_value);
      o_valid = 32'(a_if.out_valid);
      o_img  = 32'(a_if.img_addr);  o_ker   = 32'(a_if.ker_addr);
      o_idx  = 32'(a_if.out_idx);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use_b, input bit st, input bit rdy);
    if (use_b) begin
      b_if.start = st;   b_if.out_ready = rdy;
      a_if.start = 1'b0; a_if.out_ready = 1'b0;
    end else begin
      a_if.start = st;   a_if.out_ready = rdy;
      b_if.start = 1'b0; b_if.out_ready = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  o_busy,  32'd0);
    check({tag, "_done"},  o_done,  32'd0);
    check({tag, "_rd"},    o_rd,    32'd0);
    check({tag, "_acc"},   o_acc,   32'd0);
    check({tag, "_clr"},   o_clr,   32'd0);
    check({tag, "_load"},  o_load,  32'd0);
    check({tag, "_valid"}, o_valid, 32'd0);
    check({tag, "_img"},   o_img,   32'd0);
    check({tag, "_ker"},   o_ker,   32'd0);
    check({tag, "_idx"},   o_idx,   32'd0);
  endtask

  // Runs one frame; pixel phase ph: 0 clear, 1..nt read, nt+2 load, nt+3 out_valid.
  task automatic run_frame(input bit use_b, input int stall_pix, input int stall_len, input bit poke);
    int nt, kk, iw, ow, npix, p, ph, sc, k, hs, dones, done_k, tap, row, col;
    bit e_rd, e_acc, e_clr, e_load, e_val, st, rdy, finished;
    nt   = use_b ? 1 : 9;
    kk   = use_b ? 1 : 3;
    iw   = use_b ? 4 : 8;
    ow   = use_b ? 4 : 6;
    npix = use_b ? 16 : 36;
    p = 0; ph = 0; sc = 0; k = 0; hs = 0; dones = 0; done_k = -1; finished = 1'b0;
    sel_b = use_b;
    @(negedge clk);
    drive(use_b, 1'b1, 1'b1);
    @(negedge clk);
    drive(use_b, 1'b0, 1'b1);
    while (!finished && k < 3000) begin
      k++;
      if (k > 1) @(negedge clk);
      if (o_done == 32'd1) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (p == npix) begin
        check("tail_done",  o_done,  32'(ph == 0));
        check("tail_busy",  o_busy,  32'(ph == 0));
        check("tail_rd",    o_rd,    32'd0);
        check("tail_valid", o_valid, 32'd0);
        if (ph == 0) ph = 1;
        else finished = 1'b1;
        drive(use_b, 1'b0, 1'b1);
      end else begin
        e_clr  = (ph == 0);
        e_rd   = (ph >= 1) && (ph <= nt);
        e_acc  = (ph >= 2) && (ph <= nt + 1);
        e_load = (ph == nt + 2);
        e_val  = (ph == nt + 3);
        check("acc_clear", o_clr,   32'(e_clr));
        check("rd_en",     o_rd,    32'(e_rd));
        check("acc_en",    o_acc,   32'(e_acc));
        check("load",      o_load,  32'(e_load));
        check("out_valid", o_valid, 32'(e_val));
        check("busy",      o_busy,  32'd1);
        check("done",      o_done,  32'd0);
        if (e_rd) begin
          tap = ph - 1;
          row = p / ow;
          col = p % ow;
          check("img_addr", o_img, 32'((row + tap / kk) * iw + col + tap % kk));
          check("ker_addr", o_ker, 32'(tap));
          if (!use_b && p == 0) check("img_p0", o_img, 32'(p0_tab[tap]));
          if (!use_b && p == 6 && tap == 0) check("img_p6_first", o_img, 32'd8);
          if (use_b) check("img_eq_idx", o_img, 32'(p));
        end
        if (e_val) check("out_idx", o_idx, 32'(p));
        st = poke && ((p == 1 && ph == 5) || (p == 2 && ph == nt + 3));
        if (e_val) begin
          if (p == stall_pix && sc < stall_len) begin
            rdy = 1'b0;
            sc++;
          end else begin
            rdy = 1'b1;
            p++;
            ph = 0;
          end
        end else begin
          rdy = k[0];
          ph++;
        end
        if (o_valid == 32'd1 && rdy) hs++;
        drive(use_b, st, rdy);
      end
    end
    check("frame_end",  32'(finished), 32'd1);
    check("handshakes", 32'(hs),       32'(npix));
    check("done_count", 32'(dones),    32'd1);
    check("done_cycle", 32'(done_k),   32'((use_b ? 81 : 469) + (stall_len > 0 ? stall_len : 0)));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sel_b  = 1'b0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_all_zero("rst_a");
    sel_b = 1'b1;
    #1;
    check_all_zero("rst_b");
    sel_b = 1'b0;
    rst   = 1'b0;

    run_frame(1'b0, -1, 0, 1'b0);
    run_frame(1'b0, 3, 5, 1'b0);
    run_frame(1'b0, -1, 0, 1'b1);

    // Reset in the middle of the MAC walk, then restart from a clean frame.
    sel_b = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("mid_rd_en", o_rd,  32'd1);
    check("mid_img",   o_img, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid1");
    @(negedge clk);
    check_all_zero("rst_mid2");
    rst = 1'b0;
    run_frame(1'b0, -1, 0, 1'b0);

    run_frame(1'b1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
